// File: rtl/axi_adder_tree_pipe_if.sv
// AXI4-Lite slave bundle for the adder-tree peripheral; signal names follow the
// PS interconnect naming so board-level wiring stays one-to-one.
interface axi_adder_tree_pipe_if #(
  parameter int AW = 6,
  parameter int DW = 32
);
  logic [AW-1:0]   S_AXI_AWADDR;
  logic [2:0]      S_AXI_AWPROT;
  logic            S_AXI_AWVALID;
  logic            S_AXI_AWREADY;
  logic [DW-1:0]   S_AXI_WDATA;
  logic [DW/8-1:0] S_AXI_WSTRB;
  logic            S_AXI_WVALID;
  logic            S_AXI_WREADY;
  logic [1:0]      S_AXI_BRESP;
  logic            S_AXI_BVALID;
  logic            S_AXI_BREADY;
  logic [AW-1:0]   S_AXI_ARADDR;
  logic [2:0]      S_AXI_ARPROT;
  logic            S_AXI_ARVALID;
  logic            S_AXI_ARREADY;
  logic [DW-1:0]   S_AXI_RDATA;
  logic [1:0]      S_AXI_RRESP;
  logic            S_AXI_RVALID;
  logic            S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

// File: rtl/axi_adder_tree_pipe.sv
// AXI4-Lite operand bank feeding a registered binary adder tree (one level per cycle),
// with widened result, signed/unsigned mode, auto-start and sticky DONE/COUNT.
module axi_adder_tree_node #(
  parameter int W = 35
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o
);
  logic [W-1:0] sum_q;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sum_q <= '0;
    else        sum_q <= a_i + b_i;

  assign sum_o = sum_q;
endmodule

module axi_adder_tree_pipe #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int NUM_OPERANDS       = 8
) (
  input logic                  S_AXI_ACLK,
  input logic                  S_AXI_ARESETN,
  axi_adder_tree_pipe_if.slave bus
);
  localparam int DW     = C_S_AXI_DATA_WIDTH;
  localparam int AW     = C_S_AXI_ADDR_WIDTH;
  localparam int N      = NUM_OPERANDS;
  localparam int LEVELS = $clog2(N);
  localparam int RW     = DW + LEVELS;
  localparam int IW     = AW - 2;
  localparam logic [IW-1:0] IDX_CTRL = IW'(N);
  localparam logic [IW-1:0] IDX_STAT = IW'(N + 1);
  localparam logic [IW-1:0] IDX_RLO  = IW'(N + 2);
  localparam logic [IW-1:0] IDX_RHI  = IW'(N + 3);
  localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

  // Async assert, sync release of the internal reset.
  logic [1:0] rst_sync_q;
  logic       rst_n;
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN)
    if (!S_AXI_ARESETN) rst_sync_q <= '0;
    else                rst_sync_q <= {rst_sync_q[0], 1'b1};
  assign rst_n = rst_sync_q[1];

  logic                 awready_q, bvalid_q, arready_q, rvalid_q;
  logic [DW-1:0]        rdata_q, rd_mux;
  logic [N-1:0][DW-1:0] op_q;
  logic                 signed_q, auto_q, start_q, done_q;
  logic [7:0]           count_q;
  logic [DW-1:0]        res_lo_q, res_hi_q, hi_ext;
  logic [LEVELS:0]      vld_pipe, sgn_pipe;
  logic [N-1:0][RW-1:0] leaf_q;
  logic [N-1:1][RW-1:0] node;
  logic [RW-1:0]        sum;
  logic [IW-1:0]        widx, ridx;
  logic                 aw_hs, ar_hs, is_op, is_ctrl, is_stat, ctrl_go, auto_hit;
  logic                 w1c, done_evt, busy;
  logic                 unused_bits;

  assign widx     = bus.S_AXI_AWADDR[AW-1:2];
  assign ridx     = bus.S_AXI_ARADDR[AW-1:2];
  assign aw_hs    = awready_q & bus.S_AXI_AWVALID & bus.S_AXI_WVALID;
  assign ar_hs    = arready_q & bus.S_AXI_ARVALID;
  assign is_op    = widx < IDX_CTRL;
  assign is_ctrl  = widx == IDX_CTRL;
  assign is_stat  = widx == IDX_STAT;
  assign ctrl_go  = is_ctrl & bus.S_AXI_WSTRB[0] & bus.S_AXI_WDATA[0];
  assign auto_hit = (widx == IDX_LAST) & auto_q;
  assign w1c      = aw_hs & is_stat & bus.S_AXI_WDATA[1];
  assign done_evt = vld_pipe[LEVELS];
  assign busy     = |vld_pipe;
  assign sum      = node[1];
  assign unused_bits = ^{bus.S_AXI_AWPROT, bus.S_AXI_ARPROT,
                         bus.S_AXI_AWADDR[1:0], bus.S_AXI_ARADDR[1:0]};

  // Write channel and register bank
  always_ff @(posedge S_AXI_ACLK or negedge rst_n) begin
    if (!rst_n) begin
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      op_q      <= '0;
      signed_q  <= 1'b0;
      auto_q    <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      awready_q <= !awready_q && bus.S_AXI_AWVALID && bus.S_AXI_WVALID && !bvalid_q;
      start_q   <= aw_hs && (ctrl_go || auto_hit);
      if (aw_hs)                 bvalid_q <= 1'b1;
      else if (bus.S_AXI_BREADY) bvalid_q <= 1'b0;
      if (aw_hs && is_op)
        for (int b = 0; b < DW/8; b++)
          if (bus.S_AXI_WSTRB[b])
            op_q[widx[LEVELS-1:0]][8*b +: 8] <= bus.S_AXI_WDATA[8*b +: 8];
      if (aw_hs && is_ctrl && bus.S_AXI_WSTRB[0]) begin
        signed_q <= bus.S_AXI_WDATA[1];
        auto_q   <= bus.S_AXI_WDATA[2];
      end
    end
  end

  // Read channel
  always_comb begin
    rd_mux = '0;
    if (ridx < IDX_CTRL)       rd_mux = op_q[ridx[LEVELS-1:0]];
    else if (ridx == IDX_CTRL) rd_mux = {{(DW-3){1'b0}}, auto_q, signed_q, 1'b0};
    else if (ridx == IDX_STAT) rd_mux = {{(DW-16){1'b0}}, count_q, 6'b0, done_q, busy};
    else if (ridx == IDX_RLO)  rd_mux = res_lo_q;
    else if (ridx == IDX_RHI)  rd_mux = res_hi_q;
  end

  always_ff @(posedge S_AXI_ACLK or negedge rst_n) begin
    if (!rst_n) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      arready_q <= !arready_q && bus.S_AXI_ARVALID && !rvalid_q;
      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_mux;
      end else if (bus.S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  // Heap-ordered tree: node k sums children 2k/2k+1; indices >= N are the leaves.
  for (genvar k = 1; k < N; k++) begin : g_node
    logic [RW-1:0] a, b;
    if (2*k >= N) begin : g_leaf
      assign a = leaf_q[2*k - N];
      assign b = leaf_q[2*k + 1 - N];
    end else begin : g_int
      assign a = node[2*k];
      assign b = node[2*k + 1];
    end
    axi_adder_tree_node #(.W(RW)) u_node (
      .clk   (S_AXI_ACLK),
      .rst_n (rst_n),
      .a_i   (a),
      .b_i   (b),
      .sum_o (node[k])
    );
  end

  assign hi_ext = {{(2*DW-RW){sgn_pipe[LEVELS] & sum[RW-1]}}, sum[RW-1:DW]};

  always_ff @(posedge S_AXI_ACLK or negedge rst_n) begin
    if (!rst_n) begin
      leaf_q   <= '0;
      vld_pipe <= '0;
      sgn_pipe <= '0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      done_q   <= 1'b0;
      count_q  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[LEVELS-1:0], start_q};
      sgn_pipe <= {sgn_pipe[LEVELS-1:0], signed_q};
      if (start_q)
        for (int i = 0; i < N; i++)
          leaf_q[i] <= {{LEVELS{signed_q & op_q[i][DW-1]}}, op_q[i]};
      if (done_evt) begin
        res_lo_q <= sum[DW-1:0];
        res_hi_q <= hi_ext;
        count_q  <= count_q + 8'd1;
      end
      // A completion in the same cycle as the clear wins.
      done_q <= done_evt | (done_q & ~w1c);
    end
  end

  assign bus.S_AXI_AWREADY = awready_q;
  assign bus.S_AXI_WREADY  = awready_q;
  assign bus.S_AXI_BRESP   = 2'b00;
  assign bus.S_AXI_BVALID  = bvalid_q;
  assign bus.S_AXI_ARREADY = arready_q;
  assign bus.S_AXI_RDATA   = rdata_q;
  assign bus.S_AXI_RRESP   = 2'b00;
  assign bus.S_AXI_RVALID  = rvalid_q;
endmodule

// File: tb/tb_axi_adder_tree_pipe.sv
// Directed bench: reads push hand-computed expectations into a scoreboard that an
// independent monitor drains on every R handshake; B responses checked on the fly.
module tb_axi_adder_tree_pipe;
  localparam logic [5:0] A_CTRL = 6'h20, A_STAT = 6'h24, A_RLO = 6'h28, A_RHI = 6'h2C;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_adder_tree_pipe_if #(.AW(6), .DW(32)) bus ();

  axi_adder_tree_pipe #(
    .C_S_AXI_DATA_WIDTH (32),
    .C_S_AXI_ADDR_WIDTH (6),
    .NUM_OPERANDS       (8)
  ) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .bus           (bus)
  );

  typedef struct {
    string       tag;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int nvec = 0;
  int nerr = 0;

  // Monitor: pops on each accepted read beat, checks every write response.
  always @(negedge clk) begin
    exp_t e;
    if (bus.S_AXI_RVALID && bus.S_AXI_RREADY) begin
      nvec++;
      if (sb.size() == 0) begin
        nerr++;
        $display("FAIL unexpected_read got=%h", bus.S_AXI_RDATA);
      end else begin
        e = sb.pop_front();
        if (bus.S_AXI_RDATA !== e.data || bus.S_AXI_RRESP !== 2'b00) begin
          nerr++;
          $display("FAIL %s got=%h resp=%b want=%h resp=00", e.tag, bus.S_AXI_RDATA,
                   bus.S_AXI_RRESP, e.data);
        end
      end
    end
    if (bus.S_AXI_BVALID && bus.S_AXI_BREADY) begin
      nvec++;
      if (bus.S_AXI_BRESP !== 2'b00) begin
        nerr++;
        $display("FAIL bresp got=%b want=00", bus.S_AXI_BRESP);
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    nvec++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic timeout(input string tag);
    nvec++;
    nerr++;
    $display("FAIL %s timeout", tag);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s = 4'hF);
    int n = 0;
    @(negedge clk); #1;
    bus.S_AXI_AWADDR = a; bus.S_AXI_WDATA = d; bus.S_AXI_WSTRB = s;
    bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1; bus.S_AXI_BREADY = 1'b1;
    do begin @(negedge clk); n++; end while (!bus.S_AXI_AWREADY && n < 50);
    if (!bus.S_AXI_AWREADY) timeout("awready");
    @(posedge clk); #1;
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.S_AXI_BVALID && n < 50);
    if (!bus.S_AXI_BVALID) timeout("bvalid");
    @(posedge clk); #1;
    bus.S_AXI_BREADY = 1'b0;
  endtask

  task automatic rd(input logic [5:0] a, input logic [31:0] want, input string tag);
    exp_t e;
    int n = 0;
    e.tag = tag; e.data = want;
    @(negedge clk); #1;
    sb.push_back(e);
    bus.S_AXI_ARADDR = a; bus.S_AXI_ARVALID = 1'b1; bus.S_AXI_RREADY = 1'b1;
    do begin @(negedge clk); n++; end while (!bus.S_AXI_ARREADY && n < 50);
    if (!bus.S_AXI_ARREADY) timeout("arready");
    @(posedge clk); #1;
    bus.S_AXI_ARVALID = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.S_AXI_RVALID && n < 50);
    if (!bus.S_AXI_RVALID) timeout("rvalid");
    @(posedge clk); #1;
  endtask

  // RREADY held low for 3 cycles with ARVALID still asserted.
  task automatic rd_hold(input logic [5:0] a, input logic [31:0] want);
    exp_t e;
    int n = 0;
    e.tag = "hold_final"; e.data = want;
    @(negedge clk); #1;
    sb.push_back(e);
    bus.S_AXI_ARADDR = a; bus.S_AXI_ARVALID = 1'b1; bus.S_AXI_RREADY = 1'b0;
    do begin @(negedge clk); n++; end while (!bus.S_AXI_ARREADY && n < 50);
    if (!bus.S_AXI_ARREADY) timeout("hold_arready");
    @(posedge clk); #1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("hold_stable", {30'b0, bus.S_AXI_RVALID, bus.S_AXI_ARREADY, bus.S_AXI_RDATA},
            {30'b0, 1'b1, 1'b0, want});
    end
    @(posedge clk); #1;
    bus.S_AXI_RREADY = 1'b1; bus.S_AXI_ARVALID = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic chk_outs_zero(input string tag);
    check(tag, {21'b0, bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_BVALID, bus.S_AXI_ARREADY,
                bus.S_AXI_RVALID, bus.S_AXI_BRESP, bus.S_AXI_RRESP, bus.S_AXI_RDATA}, 64'd0);
  endtask

  initial begin
    int n;
    bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA = '0; bus.S_AXI_WSTRB = '0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_BREADY = 1'b0;
    bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 1'b0; bus.S_AXI_RREADY = 1'b0;
    idle(3);
    chk_outs_zero("reset_outputs");
    rst_n = 1'b1;
    idle(4);

    // reset state
    rd(A_STAT, 32'h0, "rst_status");
    rd(A_RLO,  32'h0, "rst_res_lo");
    rd(A_RHI,  32'h0, "rst_res_hi");
    rd(6'h00,  32'h0, "rst_op0");
    rd(A_CTRL, 32'h0, "rst_ctrl");

    // 1..8 -> 0x24; immediate status read catches BUSY before the result lands
    for (int i = 0; i < 8; i++) wr(6'(4*i), 32'(i + 1));
    wr(A_CTRL, 32'h1);
    rd(A_STAT, 32'h0000_0001, "t1_busy");
    rd(A_RLO,  32'h0000_0024, "t1_res_lo");
    rd(A_RHI,  32'h0,         "t1_res_hi");
    rd(A_STAT, 32'h0000_0102, "t1_status");

    // all ones, signed then unsigned
    for (int i = 0; i < 8; i++) wr(6'(4*i), 32'hFFFF_FFFF);
    wr(A_CTRL, 32'h3);
    idle(6);
    rd(A_CTRL, 32'h2,         "ctrl_start_reads0");
    rd(A_RLO,  32'hFFFF_FFF8, "t2s_res_lo");
    rd(A_RHI,  32'hFFFF_FFFF, "t2s_res_hi");
    wr(A_CTRL, 32'h1);
    idle(6);
    rd(A_RLO,  32'hFFFF_FFF8, "t2u_res_lo");
    rd(A_RHI,  32'h0000_0007, "t2u_res_hi");
    // SIGNED cleared while the signed sum is in flight
    wr(A_CTRL, 32'h3);
    wr(A_CTRL, 32'h0);
    rd(A_RHI,  32'hFFFF_FFFF, "snapshot_signed");
    rd(A_STAT, 32'h0000_0402, "t2_status");

    // back-to-back starts with OP0 changed between them
    for (int i = 0; i < 8; i++) wr(6'(4*i), 32'(i + 1));
    wr(A_STAT, 32'h2);
    rd(A_STAT, 32'h0000_0400, "w1c_clear");
    wr(A_CTRL, 32'h1);
    wr(6'h00,  32'd100);
    wr(A_CTRL, 32'h1);
    rd(A_RLO,  32'h0000_0024, "b2b_first");
    rd(A_RLO,  32'h0000_0087, "b2b_second");
    rd(A_STAT, 32'h0000_0602, "b2b_status");

    // byte strobe, then auto-start on OP7
    wr(6'h00, 32'h1234_5678);
    wr(6'h00, 32'h0000_00AB, 4'h1);
    rd(6'h00, 32'h1234_56AB, "wstrb_op0");
    wr(A_CTRL, 32'h4);
    wr(6'h1C,  32'h10);
    idle(6);
    rd(A_RLO,  32'h1234_56D6, "auto_res_lo");
    rd(A_RHI,  32'h0,         "auto_res_hi");
    rd(A_CTRL, 32'h4,         "auto_ctrl");
    wr(A_CTRL, 32'h0);
    wr(6'h1C,  32'h20);
    idle(6);
    rd(A_STAT, 32'h0000_0702, "noauto_status");

    // completion and W1C on the same edge
    wr(A_STAT, 32'h2);
    rd(A_STAT, 32'h0000_0700, "w1c_clear2");
    wr(A_CTRL, 32'h1);
    idle(2);
    wr(A_STAT, 32'h2);
    rd(A_STAT, 32'h0000_0802, "w1c_vs_done");
    rd_hold(A_RLO, 32'h1234_56E6);

    // unmapped offsets
    rd(6'h3C, 32'h0, "unmapped_rd");
    wr(6'h30, 32'hDEAD_BEEF);
    rd(6'h30, 32'h0, "unmapped_wr");

    // reset while busy
    wr(A_CTRL, 32'h1);
    @(negedge clk);
    rst_n = 1'b0;
    idle(2);
    chk_outs_zero("midreset_outputs");
    rst_n = 1'b1;
    idle(12);
    rd(A_STAT, 32'h0, "post_rst_status");
    rd(A_RLO,  32'h0, "post_rst_res_lo");
    rd(6'h00,  32'h0, "post_rst_op0");
    rd(A_CTRL, 32'h0, "post_rst_ctrl");

    n = 0;
    while (sb.size() != 0 && n < 100) begin @(negedge clk); n++; end
    if (sb.size() != 0) timeout("scoreboard_drain");
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
